instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of prefetch-queue entries (power of two, 2 to 8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 Address  output  32  byte address driven to the combinational instruction memory.
REQ-006 Instruction  input  32  word returned by the instruction memory for Address, same cycle.
REQ-007 BranchTaken  input  1  redirect request from a later stage.
REQ-008 BranchTarget  input  32  redirect byte address; bits [1:0] ignored.
REQ-009 OutReady  input  1  decode stage accepts the head entry this cycle.
REQ-010 OutValid  output  1  head entry is valid.
REQ-011 OutInstruction  output  32  head entry instruction word.
REQ-012 OutPCPlus4  output  32  head entry fetch address plus 4.
REQ-013 Count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.

Function
REQ-014 PC register SHALL hold the next fetch address; Address SHALL equal {PC[31:2],2'b00} combinationally.
REQ-015 Fetch fires in a cycle when BranchTaken=0 and (Count<FIFO_DEPTH or pop occurs that cycle).
REQ-016 On fetch, {Instruction, PC+4} SHALL be written to the queue tail and PC SHALL advance by 4 at the clock edge.
REQ-017 No fetch: PC and tail unchanged.
REQ-018 Pop occurs when OutValid=1, OutReady=1 and BranchTaken=0; the head advances by one.
REQ-019 Pop and fetch in the same cycle SHALL leave Count unchanged, including when the queue is full.
REQ-020 OutValid SHALL be 1 exactly when Count>0; OutInstruction/OutPCPlus4 SHALL reflect the head entry combinationally from registered storage (zero added latency).
REQ-021 Fetch-to-output latency: a word fetched at edge N SHALL be visible on the outputs after edge N when the queue was empty.
REQ-022 BranchTaken=1 SHALL, at the next edge, flush all entries (Count=0), load PC={BranchTarget[31:2],2'b00}, and suppress both fetch and pop that cycle.
REQ-023 BranchTaken SHALL take priority over fetch, pop and a full queue.
REQ-024 Back-to-back BranchTaken cycles: the last target wins; no entries are written.
REQ-025 PC arithmetic SHALL be modulo 2^32; PC=32'hFFFF_FFFC SHALL wrap to 0 with OutPCPlus4=0 for that entry.
REQ-026 Queue head/tail pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by Count, not by pointer equality.
REQ-027 Empty queue with OutReady=1: no pop, Count stays 0, no underflow.

Reset
REQ-028 Reset=1 at an edge SHALL set PC=RESET_PC, Count=0 and both pointers to 0, overriding BranchTaken, fetch and pop.
REQ-029 During and immediately after reset, OutValid=0 and Address=RESET_PC; OutInstruction and OutPCPlus4 read as 0.
REQ-030 Reset asserted mid-stream SHALL discard all queued entries; the first fetch after release SHALL come from RESET_PC.

Structure
REQ-031 The shared package SHALL hold WORD_W=32, INSTR_BYTES=4, the default RESET_PC and the queue entry record type {instr, pc_plus4}.
REQ-032 Queue storage SHALL be a separate sub-module, fetch_queue (synchronous push/pop/flush, Count output); PC and control logic SHALL remain in instruction_fetch_unit.

Verification
REQ-033 Reset, then OutReady=1 held, memory[i]=i*4 -> from the cycle after reset, Address=0,4,8...; OutInstruction=0,4,8... with OutPCPlus4=4,8,12..., one per cycle.
REQ-034 OutReady=0 for 6 cycles after reset -> Count reaches 4 after 4 edges, Address holds 32'h10, PC stalls; with OutReady=1, outputs 0,4,8,12,16 in order.
REQ-035 Full queue, OutReady=1 for one cycle -> Count stays 4, one pop and one fetch (Address 16->20).
REQ-036 BranchTaken=1, BranchTarget=32'h0000_0103 with 3 entries queued -> next cycle Count=0, OutValid=0, Address=32'h100; the following cycle OutInstruction=memory[64], OutPCPlus4=32'h104.
REQ-037 BranchTarget=32'hFFFF_FFFC, OutReady=1 -> entries show OutPCPlus4=0, then Address=0 and OutPCPlus4=4.
REQ-038 Reset asserted with 2 entries queued while BranchTaken=1 -> next cycle Count=0 and Address=RESET_PC (the branch is ignored).

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and the prefetch-queue entry record for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int          WORD_W           = 32;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
  } queue_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Circular prefetch queue with synchronous push/pop/flush; occupancy is tracked by an explicit count.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  queue_entry_t             push_entry,
  input  logic                     pop,
  output queue_entry_t             head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  queue_entry_t   mem_q [DEPTH];
  queue_entry_t   mem_d [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged, even when full.
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_entry = (count_q != '0) ? mem_q[head_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, fetch/pop/redirect control, feeding a prefetch queue.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                        Clk,
  input  logic                        Reset,
  output logic [WORD_W-1:0]           Address,
  input  logic [WORD_W-1:0]           Instruction,
  input  logic                        BranchTaken,
  input  logic [WORD_W-1:0]           BranchTarget,
  input  logic                        OutReady,
  output logic                        OutValid,
  output logic [WORD_W-1:0]           OutInstruction,
  output logic [WORD_W-1:0]           OutPCPlus4,
  output logic [$clog2(FIFO_DEPTH):0] Count
);

  localparam int               CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              fetch;
  logic              pop;
  queue_entry_t      push_entry;
  queue_entry_t      head_entry;
  logic [CW-1:0]     count;

  assign Address = {pc_q[WORD_W-1:2], 2'b00};

  // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
  always_comb begin
    pop        = (count != '0) && OutReady && !BranchTaken;
    fetch      = !BranchTaken && ((count < FULL_COUNT) || pop);
    push_entry = '{instr: Instruction, pc_plus4: Address + WORD_W'(INSTR_BYTES)};
    pc_d       = pc_q;
    if (BranchTaken) begin
      pc_d = {BranchTarget[WORD_W-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = Address + WORD_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_queue (
    .clk        (Clk),
    .reset      (Reset),
    .flush      (BranchTaken),
    .push       (fetch),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

  assign OutValid       = (count != '0);
  assign OutInstruction = head_entry.instr;
  assign OutPCPlus4     = head_entry.pc_plus4;
  assign Count          = count;

endmodule
